// File: rtl/lcd_frame_sequencer_pkg.sv
// Shared encodings for the LCD frame sequencer: FSM states, panel opcodes,
// RGB565 colours, default timing and the init-table entry layout.
package lcd_frame_sequencer_pkg;

  localparam logic [3:0] ST_RST_LOW   = 4'd0;
  localparam logic [3:0] ST_RST_WAIT  = 4'd1;
  localparam logic [3:0] ST_INIT_SEND = 4'd2;
  localparam logic [3:0] ST_INIT_DLY  = 4'd3;
  localparam logic [3:0] ST_READY     = 4'd4;
  localparam logic [3:0] ST_WIN_SEND  = 4'd5;
  localparam logic [3:0] ST_PIX_FETCH = 4'd6;
  localparam logic [3:0] ST_PIX_HI    = 4'd7;
  localparam logic [3:0] ST_PIX_LO    = 4'd8;
  localparam logic [3:0] ST_FRAME_END = 4'd9;

  // Byte-writer handshake phases: issue, wait for busy, wait for idle.
  localparam logic [1:0] BP_ISSUE = 2'd0;
  localparam logic [1:0] BP_LOW   = 2'd1;
  localparam logic [1:0] BP_HIGH  = 2'd2;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [7:0] COLMOD_RGB565  = 8'h55;
  localparam logic [7:0] MADCTL_DEFAULT = 8'h00;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  localparam int DEF_LCD_W   = 240;
  localparam int DEF_LCD_H   = 320;
  localparam int DEF_RST_CYC = 500_000;
  localparam int DEF_DLY_CYC = 6_000_000;

  typedef struct packed {
    logic       is_cmd;
    logic       has_delay;
    logic [7:0] data;
    logic       last;
  } init_entry_t;

endpackage

// File: rtl/lcd_init_rom.sv
// Panel initialisation table: index -> {is_cmd, has_delay, byte, last}.
module lcd_init_rom
  import lcd_frame_sequencer_pkg::*;
(
  input  logic [2:0]  idx,
  output init_entry_t entry
);

  // NOTE: assign every combinational output a default first so no path infers a latch.
  always_comb begin
    entry = '{is_cmd: 1'b0, has_delay: 1'b0, data: 8'h00, last: 1'b1};
    case (idx)
      3'd0: entry = '{1'b1, 1'b1, CMD_SWRESET,    1'b0};
      3'd1: entry = '{1'b1, 1'b1, CMD_SLPOUT,     1'b0};
      3'd2: entry = '{1'b1, 1'b0, CMD_COLMOD,     1'b0};
      3'd3: entry = '{1'b0, 1'b0, COLMOD_RGB565,  1'b0};
      3'd4: entry = '{1'b1, 1'b0, CMD_MADCTL,     1'b0};
      3'd5: entry = '{1'b0, 1'b0, MADCTL_DEFAULT, 1'b0};
      3'd6: entry = '{1'b1, 1'b0, CMD_DISPON,     1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Panel power-up, init-command and full-frame pixel streaming sequencer driving
// an 8-bit command/data byte writer through a start/done handshake.
module lcd_frame_sequencer
  import lcd_frame_sequencer_pkg::*;
#(
  parameter int LCD_W   = DEF_LCD_W,
  parameter int LCD_H   = DEF_LCD_H,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int DLY_CYC = DEF_DLY_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_req,
  input  logic [15:0] pix_color,
  input  logic        wr_done,
  output logic        wr_start,
  output logic [7:0]  wr_data,
  output logic        wr_dc,
  output logic        pix_req,
  output logic [7:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        lcd_rst,
  output logic        lcd_cs,
  output logic        init_done,
  output logic        frame_busy,
  output logic        frame_done
);

  localparam logic [15:0] COL_END  = 16'(LCD_W - 1);
  localparam logic [15:0] ROW_END  = 16'(LCD_H - 1);
  localparam logic [31:0] RST_LAST = 32'(RST_CYC - 1);
  localparam logic [31:0] DLY_LAST = 32'(DLY_CYC - 1);
  localparam logic [3:0]  WIN_LAST = 4'd10;

  logic [3:0]  state;
  logic [31:0] cnt;
  logic [2:0]  init_idx;
  logic [3:0]  win_idx;
  logic [1:0]  bphase;
  logic [1:0]  fetch_ph;
  logic [15:0] color_q;

  init_entry_t rom;
  logic [7:0]  win_byte;
  logic        win_dc;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        tx_active;
  logic        byte_done;
  logic        x_last;
  logic        y_last;

  lcd_init_rom u_init_rom (
    .idx   (init_idx),
    .entry (rom)
  );

  assign x_last = (pix_x == COL_END[7:0]);
  assign y_last = (pix_y == ROW_END[8:0]);

  // Address window: CASET 0..LCD_W-1, RASET 0..LCD_H-1, then RAMWR.
  always_comb begin
    win_byte = 8'h00;
    win_dc   = 1'b1;
    case (win_idx)
      4'd0:    begin win_byte = CMD_CASET; win_dc = 1'b0; end
      4'd3:    win_byte = COL_END[15:8];
      4'd4:    win_byte = COL_END[7:0];
      4'd5:    begin win_byte = CMD_RASET; win_dc = 1'b0; end
      4'd8:    win_byte = ROW_END[15:8];
      4'd9:    win_byte = ROW_END[7:0];
      4'd10:   begin win_byte = CMD_RAMWR; win_dc = 1'b0; end
      default: ;
    endcase
  end

  // Every byte-producing state funnels through this mux into the single handshake.
  always_comb begin
    tx_byte   = 8'h00;
    tx_dc     = 1'b0;
    tx_active = 1'b0;
    case (state)
      ST_INIT_SEND: begin tx_active = 1'b1; tx_byte = rom.data;      tx_dc = ~rom.is_cmd; end
      ST_WIN_SEND:  begin tx_active = 1'b1; tx_byte = win_byte;      tx_dc = win_dc;      end
      ST_PIX_HI:    begin tx_active = 1'b1; tx_byte = color_q[15:8]; tx_dc = 1'b1;        end
      ST_PIX_LO:    begin tx_active = 1'b1; tx_byte = color_q[7:0];  tx_dc = 1'b1;        end
      default: ;
    endcase
  end

  assign byte_done = tx_active && (bphase == BP_HIGH) && wr_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_start <= 1'b0;
      wr_data  <= 8'h00;
      wr_dc    <= 1'b0;
      bphase   <= BP_ISSUE;
    end else begin
      wr_start <= 1'b0;
      if (tx_active) begin
        case (bphase)
          BP_ISSUE: if (wr_done) begin
            wr_start <= 1'b1;
            wr_data  <= tx_byte;
            wr_dc    <= tx_dc;
            bphase   <= BP_LOW;
          end
          BP_LOW:  if (!wr_done) bphase <= BP_HIGH;
          BP_HIGH: if (wr_done)  bphase <= BP_ISSUE;
          default: bphase <= BP_ISSUE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST_LOW;
      cnt        <= 32'd0;
      init_idx   <= 3'd0;
      win_idx    <= 4'd0;
      fetch_ph   <= 2'd0;
      color_q    <= 16'h0000;
      pix_req    <= 1'b0;
      pix_x      <= 8'd0;
      pix_y      <= 9'd0;
      lcd_rst    <= 1'b0;
      lcd_cs     <= 1'b1;
      init_done  <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_RST_LOW: begin
          if (cnt == RST_LAST) begin
            cnt     <= 32'd0;
            lcd_rst <= 1'b1;
            state   <= ST_RST_WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_RST_WAIT: begin
          if (cnt == DLY_LAST) begin
            cnt      <= 32'd0;
            init_idx <= 3'd0;
            lcd_cs   <= 1'b0;
            state    <= ST_INIT_SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_INIT_SEND: begin
          if (byte_done) begin
            if (rom.has_delay) begin
              cnt   <= 32'd0;
              state <= ST_INIT_DLY;
            end else if (rom.last) begin
              init_done <= 1'b1;
              lcd_cs    <= 1'b1;
              state     <= ST_READY;
            end else begin
              init_idx <= init_idx + 3'd1;
            end
          end
        end
        ST_INIT_DLY: begin
          if (cnt == DLY_LAST) begin
            cnt      <= 32'd0;
            init_idx <= init_idx + 3'd1;
            state    <= ST_INIT_SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_READY: begin
          if (frame_req) begin
            frame_busy <= 1'b1;
            pix_x      <= 8'd0;
            pix_y      <= 9'd0;
            lcd_cs     <= 1'b0;
            win_idx    <= 4'd0;
            state      <= ST_WIN_SEND;
          end
        end
        ST_WIN_SEND: begin
          if (byte_done) begin
            if (win_idx == WIN_LAST) begin
              fetch_ph <= 2'd0;
              state    <= ST_PIX_FETCH;
            end else begin
              win_idx <= win_idx + 4'd1;
            end
          end
        end
        // Strobe, let the colour source answer, then capture it.
        ST_PIX_FETCH: begin
          case (fetch_ph)
            2'd0: begin pix_req <= 1'b1; fetch_ph <= 2'd1; end
            2'd1: begin pix_req <= 1'b0; fetch_ph <= 2'd2; end
            default: begin
              color_q  <= pix_color;
              fetch_ph <= 2'd0;
              state    <= ST_PIX_HI;
            end
          endcase
        end
        ST_PIX_HI: if (byte_done) state <= ST_PIX_LO;
        ST_PIX_LO: begin
          if (byte_done) begin
            if (x_last) begin
              pix_x <= 8'd0;
              if (y_last) begin
                pix_y      <= 9'd0;
                frame_done <= 1'b1;
                frame_busy <= 1'b0;
                lcd_cs     <= 1'b1;
                state      <= ST_FRAME_END;
              end else begin
                pix_y <= pix_y + 9'd1;
                state <= ST_PIX_FETCH;
              end
            end else begin
              pix_x <= pix_x + 8'd1;
              state <= ST_PIX_FETCH;
            end
          end
        end
        ST_FRAME_END: begin
          frame_done <= 1'b0;
          state      <= ST_READY;
        end
        default: state <= ST_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer on a 4x2 panel with short reset/delay
// timing and a behavioural byte writer plus colour source.
module tb_lcd_frame_sequencer;

  localparam int W       = 4;
  localparam int H       = 2;
  localparam int RST_CYC = 4;
  localparam int DLY_CYC = 8;
  // {lcd_rst, lcd_cs, wr_start, wr_data, wr_dc, pix_req, pix_x, pix_y, init_done, frame_busy, frame_done}
  localparam logic [32:0] RST_VEC = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 9'h000, 3'b000};

  logic        clk;
  logic        rst_n;
  logic        frame_req;
  logic [15:0] pix_color = 16'h0000;
  logic        wr_done   = 1'b1;
  logic        wr_start;
  logic [7:0]  wr_data;
  logic        wr_dc;
  logic        pix_req;
  logic [7:0]  pix_x;
  logic [8:0]  pix_y;
  logic        lcd_rst;
  logic        lcd_cs;
  logic        init_done;
  logic        frame_busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         gap_q[$];
  bit         sb_en   = 1'b1;
  bit         wr_rand = 1'b0;
  int cyc = 0, last_cmpl = 0, lat_left = 0, fd_cnt = 0;
  int stab_viol = 0, start_viol = 0, cs_viol = 0, fd_viol = 0;
  logic [8:0] held = 9'h000, got, want;
  logic       prev_fd = 1'b0;

  lcd_frame_sequencer #(
    .LCD_W   (W),
    .LCD_H   (H),
    .RST_CYC (RST_CYC),
    .DLY_CYC (DLY_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_req  (frame_req),
    .pix_color  (pix_color),
    .wr_done    (wr_done),
    .wr_start   (wr_start),
    .wr_data    (wr_data),
    .wr_dc      (wr_dc),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .lcd_rst    (lcd_rst),
    .lcd_cs     (lcd_cs),
    .init_done  (init_done),
    .frame_busy (frame_busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor, scoreboard, byte-writer model and colour source, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      held = 9'h000;
    end else begin
      got = {wr_dc, wr_data};
      if (wr_start) begin
        if (!wr_done) start_viol++;
        gap_q.push_back(cyc - last_cmpl);
        held = got;
        if (sb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte_sb: got dc/data %03h, required no further byte", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL byte_sb: got dc/data %03h, required %03h", got, want);
            end
          end
        end
      end else if (!wr_done && got !== held) begin
        stab_viol++;
      end
      if (lcd_cs && (wr_start || frame_busy)) cs_viol++;
      if (frame_done) begin
        fd_cnt++;
        if (prev_fd) fd_viol++;
      end
    end
    prev_fd = frame_done;
    if (wr_done) begin
      if (wr_start) begin
        wr_done  = 1'b0;
        lat_left = wr_rand ? int'($urandom_range(20, 1)) : 5;
      end
    end else begin
      lat_left--;
      if (lat_left <= 0) begin
        wr_done   = 1'b1;
        last_cmpl = cyc;
      end
    end
    if (pix_req) pix_color = {pix_y[7:0], pix_x};
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h3A});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b0, 8'h36});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h29});
  endtask

  task automatic push_frame();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h03});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h01});
    exp_q.push_back({1'b0, 8'h2C});
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        exp_q.push_back({1'b1, 8'(y)});
        exp_q.push_back({1'b1, 8'(x)});
      end
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_rst, lcd_cs, wr_start, wr_data, wr_dc, pix_req, pix_x, pix_y,
         init_done, frame_busy, frame_done} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: got %09h, required %09h",
               {lcd_rst, lcd_cs, wr_start, wr_data, wr_dc, pix_req, pix_x, pix_y,
                init_done, frame_busy, frame_done}, RST_VEC);
    end
    push_init();
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!lcd_rst && n < 100);
    checks++;
    if (n !== RST_CYC) begin
      errors++;
      $display("FAIL lcd_rst_low_cycles: got %0d, required %0d", n, RST_CYC);
    end
  endtask

  task automatic test_init();
    int i;
    gap_q.delete();
    i = 0;
    while (!init_done && i < 2000) begin
      @(negedge clk);
      i++;
      frame_req = (i == 20 || i == 40);
    end
    frame_req = 1'b0;
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL init_timeout: init_done got %0b after %0d cycles, required 1", init_done, i);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_bytes: got %0d bytes unsent at init_done, required 0", exp_q.size());
    end
    checks++;
    if (gap_q.size() < 4) begin
      errors++;
      $display("FAIL init_gap_count: got %0d starts, required at least 4", gap_q.size());
    end else begin
      if (gap_q[1] < DLY_CYC) begin
        errors++;
        $display("FAIL delay_after_01: got %0d cycles, required >= %0d", gap_q[1], DLY_CYC);
      end
      checks++;
      if (gap_q[2] < DLY_CYC) begin
        errors++;
        $display("FAIL delay_after_11: got %0d cycles, required >= %0d", gap_q[2], DLY_CYC);
      end
      checks++;
      if (gap_q[3] >= DLY_CYC) begin
        errors++;
        $display("FAIL no_delay_after_3A: got %0d cycles, required < %0d", gap_q[3], DLY_CYC);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({frame_busy, lcd_cs} !== 2'b01) begin
      errors++;
      $display("FAIL ready_idle: got busy/cs %02b, required 01", {frame_busy, lcd_cs});
    end
  endtask

  task automatic test_frame();
    int i, fd0;
    fd0 = fd_cnt;
    push_frame();
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checks++;
    if ({frame_busy, lcd_cs, pix_x, pix_y} !== {1'b1, 1'b0, 8'h00, 9'h000}) begin
      errors++;
      $display("FAIL frame_start: got busy/cs/x/y %0b/%0b/%0d/%0d, required 1/0/0/0",
               frame_busy, lcd_cs, pix_x, pix_y);
    end
    i = 0;
    while (!frame_done && i < 5000) begin
      @(negedge clk);
      i++;
      frame_req = (i == 40);
    end
    frame_req = 1'b0;
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_timeout: frame_done got 0 after %0d cycles, required 1", i);
    end
    checks++;
    if ({frame_busy, lcd_cs, pix_x, pix_y} !== {1'b0, 1'b1, 8'h00, 9'h000}) begin
      errors++;
      $display("FAIL frame_end: got busy/cs/x/y %0b/%0b/%0d/%0d, required 0/1/0/0",
               frame_busy, lcd_cs, pix_x, pix_y);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_bytes: got %0d bytes unsent, required 0", exp_q.size());
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d, required 1", fd_cnt - fd0);
    end
    checks++;
    if (cs_viol != 0) begin
      errors++;
      $display("FAIL cs_during_frame: got %0d cycles with cs high, required 0", cs_viol);
    end
  endtask

  task automatic test_back_to_back();
    int i, n, fd0;
    fd0 = fd_cnt;
    wr_rand = 1'b1;
    push_frame();
    push_frame();
    @(negedge clk);
    frame_req = 1'b1;
    i = 0;
    do begin @(negedge clk); i++; end while (!frame_done && i < 5000);
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_start && n < 20);
    frame_req = 1'b0;
    checks++;
    if (!wr_start || n > 3) begin
      errors++;
      $display("FAIL b2b_restart: got %0d cycles from frame_done to next start, required <= 3", n);
    end
    i = 0;
    while (!frame_done && i < 5000) begin @(negedge clk); i++; end
    repeat (40) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_bytes: got %0d bytes unsent, required 0", exp_q.size());
    end
    checks++;
    if (fd_cnt - fd0 != 2) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d, required 2", fd_cnt - fd0);
    end
  endtask

  task automatic test_handshake_rules();
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL data_stable: got %0d changes while busy, required 0", stab_viol);
    end
    checks++;
    if (start_viol != 0) begin
      errors++;
      $display("FAIL start_while_busy: got %0d, required 0", start_viol);
    end
    checks++;
    if (fd_viol != 0) begin
      errors++;
      $display("FAIL frame_done_pulse: got %0d multi-cycle pulses, required 0", fd_viol);
    end
  endtask

  task automatic test_reset_mid_pixel();
    int i, np;
    sb_en = 1'b0;
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    np = 0;
    i = 0;
    while (np < 3 && i < 5000) begin
      @(negedge clk);
      i++;
      if (pix_req) np++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!frame_busy) begin
      errors++;
      $display("FAIL mid_frame_setup: frame_busy got 0, required 1");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lcd_rst, lcd_cs, wr_start, wr_data, wr_dc, pix_req, pix_x, pix_y,
         init_done, frame_busy, frame_done} !== RST_VEC) begin
      errors++;
      $display("FAIL mid_reset_values: got %09h, required %09h",
               {lcd_rst, lcd_cs, wr_start, wr_data, wr_dc, pix_req, pix_x, pix_y,
                init_done, frame_busy, frame_done}, RST_VEC);
    end
    exp_q.delete();
    push_init();
    @(negedge clk);
    sb_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    i = 0;
    while (!init_done && i < 3000) begin @(negedge clk); i++; end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL reinit_timeout: init_done got 0 after %0d cycles, required 1", i);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reinit_bytes: got %0d bytes unsent, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    frame_req = 1'b0;
    test_reset();
    test_init();
    test_frame();
    test_back_to_back();
    test_handshake_rules();
    test_reset_mid_pixel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sequencer.md
LCD_FRAME_SEQUENCER -- requirements
Module: lcd_frame_sequencer

Interface
REQ-001 Parameter LCD_W, default 240, panel columns; window column end = LCD_W-1.
REQ-002 Parameter LCD_H, default 320, panel rows; window row end = LCD_H-1.
REQ-003 Parameter RST_CYC, default 500_000, number of cycles lcd_rst is held low after reset (10 ms at 50 MHz).
REQ-004 Parameter DLY_CYC, default 6_000_000, post-command delay in cycles (120 ms at 50 MHz).
REQ-005 clk  in  1  system clock, 50 MHz; one clock domain only.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 frame_req  in  1  level request to draw one full frame.
REQ-008 pix_color  in  16  RGB565 colour for (pix_x, pix_y); valid the cycle after pix_req.
REQ-009 wr_done  in  1  byte writer idle (high) / busy (low).
REQ-010 wr_start  out  1  one-cycle byte-issue pulse.
REQ-011 wr_data  out  8  byte to send.
REQ-012 wr_dc  out  1  0 = command, 1 = data.
REQ-013 pix_req  out  1  one-cycle colour fetch strobe.
REQ-014 pix_x  out  8  current column; pix_y  out  9  current row.
REQ-015 lcd_rst  out  1  panel reset; lcd_cs  out  1  chip select, active-low.
REQ-016 init_done  out  1  level, panel initialised; frame_busy  out  1  level; frame_done  out  1  one-cycle pulse.

Function
REQ-017 States: RST_LOW, RST_WAIT, INIT_SEND, INIT_DLY, READY, WIN_SEND, PIX_FETCH, PIX_HI, PIX_LO, FRAME_END.
REQ-018 RST_LOW holds lcd_rst=0 for RST_CYC cycles, then goes to RST_WAIT; RST_WAIT holds lcd_rst=1 for DLY_CYC cycles, then goes to INIT_SEND.
REQ-019 Init table, in order: cmd 01 [delay], cmd 11 [delay], cmd 3A, data 55, cmd 36, data 00, cmd 29; a [delay] entry enters INIT_DLY for DLY_CYC cycles after that byte completes.
REQ-020 The state after the last init byte is READY, with init_done set to 1; init_done stays 1 until reset.
REQ-021 Byte handshake: wr_start pulses only when wr_done=1.
REQ-022 wr_data and wr_dc stay stable from the wr_start cycle until completion.
REQ-023 A byte is complete when wr_done is seen low and then high again.
REQ-024 The next wr_start is issued no earlier than the cycle after completion.
REQ-025 In READY, frame_req=1 starts a frame: frame_busy=1, pix_x=0, pix_y=0, lcd_cs=0, then WIN_SEND.
REQ-026 frame_req is sampled only in READY; requests made outside READY are dropped, and a held request gives back-to-back frames.
REQ-027 WIN_SEND sends: cmd 2A, data 00, data 00, data (LCD_W-1)[15:8], data (LCD_W-1)[7:0]; cmd 2B, data 00, data 00, data (LCD_H-1)[15:8], data (LCD_H-1)[7:0]; cmd 2C.
REQ-028 PIX_FETCH pulses pix_req, and pix_color is captured one cycle later.
REQ-029 PIX_HI sends data pix_color[15:8]; PIX_LO sends data pix_color[7:0].
REQ-030 After PIX_LO completes: if pix_x=LCD_W-1, pix_x wraps to 0 and pix_y increments; otherwise pix_x increments.
REQ-031 If pix_x=LCD_W-1 and pix_y=LCD_H-1 at PIX_LO completion, go to FRAME_END; otherwise go to PIX_FETCH.
REQ-032 FRAME_END: frame_done=1 for one cycle, frame_busy=0, lcd_cs=1, pix_x/pix_y=0, then READY.
REQ-033 lcd_cs is 0 in INIT_SEND, INIT_DLY, WIN_SEND, PIX_* and 1 in every other state.
REQ-034 All outputs are registered.

Reset
REQ-035 rst_n low forces RST_LOW from any state, including mid-byte and mid-frame.
REQ-036 Reset values: lcd_rst=0, lcd_cs=1, wr_start=0, wr_data=00, wr_dc=0, pix_req=0, pix_x=0, pix_y=0, init_done=0, frame_busy=0, frame_done=0; all counters 0.

Structure
REQ-037 A shared package holds the state encoding, command opcodes (01, 11, 3A, 36, 29, 2A, 2B, 2C), RGB565 colour constants and default timing values.
REQ-038 The init table is a sub-module lcd_init_rom: combinational index -> {is_cmd, has_delay, byte, last}.
REQ-039 The byte-writer handshake is implemented once and shared by INIT_SEND, WIN_SEND and PIX_*.

Verification
REQ-040 RST_CYC=4, DLY_CYC=8 with a writer model that holds done low for 5 cycles -> lcd_rst low exactly 4 cycles; 7 init bytes in table order; delays of at least 8 cycles after bytes 01 and 11; init_done rises after 29.
REQ-041 LCD_W=4, LCD_H=2, single frame_req pulse, pix_color={pix_y,pix_x} -> 11 window bytes 2A 00 00 00 03 2B 00 00 00 01 2C, then 16 data bytes in raster order; frame_done one pulse; lcd_cs low throughout the frame.
REQ-042 frame_req held high -> second frame's 2A starts within 3 cycles of frame_done; no byte is lost or duplicated.
REQ-043 frame_req pulses during init and mid-frame -> ignored; exactly one frame drawn.
REQ-044 rst_n asserted mid-pixel -> all outputs take their reset values immediately, and the init sequence restarts from byte 01.
REQ-045 Writer model with done-low latency of 1 to 20 cycles (random) -> wr_data/wr_dc never change while done is low; wr_start is never issued while done is low.
